// File: rtl/ddr_slave_arbiter.sv
// Round-robin arbiter sharing one DDR burst-command port among up to four slaves.
// It also owns the frame-bank rotation that all slaves consume.
module ddr_slave_arbiter #(
    parameter int unsigned SLAVE_NUM = 4,
    parameter logic [15:0] TIMEOUT   = 16'd4096,
    parameter logic [1:0]  BANK_NUM  = 2'd3
) (
    input  logic         ddr_clk,
    input  logic         sys_rstn,
    input  logic [3:0]   slave_req,
    input  logic [99:0]  slave_waddr_bus,
    input  logic [39:0]  slave_burst_bus,
    output logic [3:0]   arbitrate_valid,
    output logic         ddr_cmd_en,
    output logic [24:0]  ddr_cmd_addr,
    output logic [9:0]   ddr_cmd_bl,
    input  logic         ddr_cmd_ready,
    input  logic         ddr_burst_done,
    input  logic         frame_sync,
    output logic [1:0]   slave_wrbank,
    output logic         slave_wr_load,
    output logic         timeout_err
);

    localparam int unsigned NS = 4;
    localparam int unsigned AW = 25;
    localparam int unsigned BW = 10;
    localparam int unsigned CW = 16;
    localparam logic [NS-1:0] SLAVE_MASK = NS'((1 << SLAVE_NUM) - 1);

    typedef enum logic [1:0] {IDLE, CMD, BUSY, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [1:0]    gnt, gnt_nxt;
    logic          pend, pend_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [NS-1:0] valid_nxt;
    logic          cmd_en_nxt;
    logic [AW-1:0] addr_nxt;
    logic [BW-1:0] bl_nxt;
    logic [1:0]    bank_nxt;
    logic          load_nxt;
    logic          terr_nxt;

    logic [NS-1:0] req_m;
    logic          pick_vld;
    logic [1:0]    pick;
    logic [2:0]    idx;

    // First active request at or above the pointer, wrapping at SLAVE_NUM.
    always_comb begin
        req_m    = slave_req & SLAVE_MASK;
        pick_vld = 1'b0;
        pick     = 2'd0;
        idx      = 3'd0;
        for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
            idx = 3'(ptr) + 3'(i);
            if (idx >= 3'(SLAVE_NUM)) idx = idx - 3'(SLAVE_NUM);
            if (!pick_vld && req_m[idx[1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[1:0];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_nxt    = gnt;
        pend_nxt   = pend | frame_sync;
        cnt_nxt    = cnt;
        valid_nxt  = arbitrate_valid;
        cmd_en_nxt = ddr_cmd_en;
        addr_nxt   = ddr_cmd_addr;
        bl_nxt     = ddr_cmd_bl;
        bank_nxt   = slave_wrbank;
        load_nxt   = 1'b0;
        terr_nxt   = timeout_err;
        case (state)
            IDLE: begin
                // A pending bank rotation takes the whole idle cycle; no grant alongside it.
                if (pend) begin
                    bank_nxt = (slave_wrbank == BANK_NUM) ? 2'd0 : slave_wrbank + 2'd1;
                    load_nxt = 1'b1;
                    pend_nxt = frame_sync;
                end else if (pick_vld) begin
                    gnt_nxt    = pick;
                    valid_nxt  = NS'(1) << pick;
                    cmd_en_nxt = 1'b1;
                    addr_nxt   = slave_waddr_bus[AW*pick +: AW];
                    bl_nxt     = slave_burst_bus[BW*pick +: BW];
                    state_nxt  = CMD;
                end
            end
            CMD: begin
                if (ddr_cmd_ready) begin
                    cmd_en_nxt = 1'b0;
                    cnt_nxt    = '0;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                if (ddr_burst_done) begin
                    valid_nxt = '0;
                    state_nxt = RELEASE;
                end else if (cnt == TIMEOUT - 16'd1) begin
                    valid_nxt = '0;
                    terr_nxt  = 1'b1;
                    state_nxt = RELEASE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RELEASE: begin
                ptr_nxt   = (gnt == 2'(SLAVE_NUM - 1)) ? 2'd0 : gnt + 2'd1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ddr_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state           <= IDLE;
            ptr             <= 2'd0;
            gnt             <= 2'd0;
            pend            <= 1'b0;
            cnt             <= '0;
            arbitrate_valid <= '0;
            ddr_cmd_en      <= 1'b0;
            ddr_cmd_addr    <= '0;
            ddr_cmd_bl      <= '0;
            slave_wrbank    <= 2'd0;
            slave_wr_load   <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state           <= state_nxt;
            ptr             <= ptr_nxt;
            gnt             <= gnt_nxt;
            pend            <= pend_nxt;
            cnt             <= cnt_nxt;
            arbitrate_valid <= valid_nxt;
            ddr_cmd_en      <= cmd_en_nxt;
            ddr_cmd_addr    <= addr_nxt;
            ddr_cmd_bl      <= bl_nxt;
            slave_wrbank    <= bank_nxt;
            slave_wr_load   <= load_nxt;
            timeout_err     <= terr_nxt;
        end
    end

endmodule

// File: tb/tb_ddr_slave_arbiter.sv
// Directed bench for ddr_slave_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_ddr_slave_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [99:0]  waddr_bus;
    logic [39:0]  burst_bus;
    logic [3:0]   valid;
    logic         cmd_en;
    logic [24:0]  cmd_addr;
    logic [9:0]   cmd_bl;
    logic         rdy;
    logic         done;
    logic         fs;
    logic [1:0]   wrbank;
    logic         wr_load;
    logic         terr;

    int checks   = 0;
    int failures = 0;

    logic [24:0] exp_addr [4];
    logic [9:0]  exp_bl   [4];

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       done;
        logic       fs;
        logic [3:0] valid;
        logic       en;
        logic [1:0] bank;
        logic       load;
    } vec_t;

    vec_t vecs [18];

    ddr_slave_arbiter dut (
        .ddr_clk         (clk),
        .sys_rstn        (rst_n),
        .slave_req       (req),
        .slave_waddr_bus (waddr_bus),
        .slave_burst_bus (burst_bus),
        .arbitrate_valid (valid),
        .ddr_cmd_en      (cmd_en),
        .ddr_cmd_addr    (cmd_addr),
        .ddr_cmd_bl      (cmd_bl),
        .ddr_cmd_ready   (rdy),
        .ddr_burst_done  (done),
        .frame_sync      (fs),
        .slave_wrbank    (wrbank),
        .slave_wr_load   (wr_load),
        .timeout_err     (terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic set_in(input logic [3:0] r, input logic y, input logic d, input logic f);
        req  = r;
        rdy  = y;
        done = d;
        fs   = f;
    endtask

    task automatic load_bus();
        for (int i = 0; i < 4; i++) begin
            waddr_bus[25*i +: 25] = exp_addr[i];
            burst_bus[10*i +: 10] = exp_bl[i];
        end
    endtask

    task automatic do_reset();
        set_in(4'b0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int grants [5];
        int ng;
        int zrun;
        int bad;
        int busy;
        logic [3:0] prev;
        logic last_err;

        exp_addr[0] = 25'h0000010; exp_bl[0] = 10'd16;
        exp_addr[1] = 25'h0040100; exp_bl[1] = 10'd256;
        exp_addr[2] = 25'h1ABCDEF; exp_bl[2] = 10'd1023;
        exp_addr[3] = 25'h1FFFFFF; exp_bl[3] = 10'd1;
        load_bus();
        rst_n = 1'b1;

        //            req      rdy   done  fs    valid    en    bank  load
        vecs[0]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0};
        vecs[4]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[5]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[6]  = '{4'b0111, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd0, 1'b0};
        vecs[7]  = '{4'b0111, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0};
        vecs[8]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[9]  = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[10] = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[11] = '{4'b0011, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[12] = '{4'b0011, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0};
        vecs[13] = '{4'b0011, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
        vecs[14] = '{4'b0011, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[15] = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[16] = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b1};
        vecs[17] = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};

        do_reset();
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_cmd_en", 32'(cmd_en), 32'd0);
        chk("reset_addr", 32'(cmd_addr), 32'd0);
        chk("reset_bl", 32'(cmd_bl), 32'd0);
        chk("reset_bank", 32'(wrbank), 32'd0);
        chk("reset_load", 32'(wr_load), 32'd0);
        chk("reset_terr", 32'(terr), 32'd0);

        for (int i = 0; i < 18; i++) begin
            set_in(vecs[i].req, vecs[i].rdy, vecs[i].done, vecs[i].fs);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_en", i), 32'(cmd_en), 32'(vecs[i].en));
            chk($sformatf("vec%0d_bank", i), 32'(wrbank), 32'(vecs[i].bank));
            chk($sformatf("vec%0d_load", i), 32'(wr_load), 32'(vecs[i].load));
            if (vecs[i].en) begin
                chk($sformatf("vec%0d_addr", i), 32'(cmd_addr), 32'(exp_addr[oh_idx(vecs[i].valid)]));
                chk($sformatf("vec%0d_bl", i), 32'(cmd_bl), 32'(exp_bl[oh_idx(vecs[i].valid)]));
            end
        end

        // Fairness: all requests held, immediate ready/done.
        do_reset();
        set_in(4'b1111, 1'b1, 1'b1, 1'b0);
        ng   = 0;
        zrun = 0;
        prev = 4'b0000;
        for (int c = 0; c < 100 && ng < 5; c++) begin
            step();
            if (prev == 4'b0000 && valid != 4'b0000) begin
                grants[ng] = oh_idx(valid);
                if (ng > 0) chk($sformatf("rr_gap%0d", ng), 32'(zrun), 32'd2);
                ng++;
                zrun = 0;
            end else if (valid == 4'b0000) begin
                zrun++;
            end
            prev = valid;
        end
        chk("rr_grant_count", 32'(ng), 32'd5);
        for (int i = 0; i < ng; i++) chk($sformatf("rr_order%0d", i), 32'(grants[i]), 32'(i % 4));

        // Backpressure: command held stable while ready is low, even if the bus changes.
        do_reset();
        set_in(4'b0100, 1'b0, 1'b0, 1'b0);
        step();
        chk("bp_grant", 32'(valid), 32'h4);
        req = 4'b0000;
        waddr_bus[50 +: 25] = 25'h0123456;
        burst_bus[20 +: 10] = 10'd7;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (cmd_en !== 1'b1 || valid !== 4'b0100 || cmd_addr !== exp_addr[2] || cmd_bl !== exp_bl[2])
                bad++;
        end
        chk("bp_hold_bad_cycles", 32'(bad), 32'd0);
        load_bus();
        rdy = 1'b1;
        step();
        chk("bp_accept_en", 32'(cmd_en), 32'd0);
        chk("bp_accept_valid", 32'(valid), 32'h4);

        // Bank rotation: coincident frame_sync, then deferral through a burst.
        do_reset();
        set_in(4'b0000, 1'b0, 1'b0, 1'b1); step();
        chk("bk_pend_bank", 32'(wrbank), 32'd0);
        step();
        chk("bk_first_bank", 32'(wrbank), 32'd1);
        chk("bk_first_load", 32'(wr_load), 32'd1);
        fs = 1'b0; step();
        chk("bk_coincident_bank", 32'(wrbank), 32'd2);
        chk("bk_coincident_load", 32'(wr_load), 32'd1);
        step();
        chk("bk_load_drop", 32'(wr_load), 32'd0);
        fs = 1'b1; step();
        fs = 1'b0; step();
        chk("bk_to3_bank", 32'(wrbank), 32'd3);
        set_in(4'b1000, 1'b0, 1'b0, 1'b0); step();
        chk("bk_grant3", 32'(valid), 32'h8);
        rdy = 1'b1; step();
        rdy = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            fs = (c % 2 == 0);
            step();
            if (wrbank !== 2'd3 || wr_load !== 1'b0 || valid !== 4'b1000) bad++;
        end
        fs = 1'b0;
        chk("bk_busy_no_change", 32'(bad), 32'd0);
        done = 1'b1; step();
        chk("bk_release_valid", 32'(valid), 32'd0);
        chk("bk_release_bank", 32'(wrbank), 32'd3);
        done = 1'b0; step();
        chk("bk_idle_bank", 32'(wrbank), 32'd3);
        step();
        chk("bk_wrap_bank", 32'(wrbank), 32'd0);
        chk("bk_wrap_load", 32'(wr_load), 32'd1);
        chk("bk_wrap_nogrant", 32'(valid), 32'd0);
        step();
        chk("bk_after_grant", 32'(valid), 32'h8);
        chk("bk_after_load", 32'(wr_load), 32'd0);

        // Timeout: slave 3 granted, no burst completion.
        rdy = 1'b1; step();
        rdy = 1'b0;
        busy = 1;
        last_err = terr;
        for (int c = 0; c < 5000 && valid == 4'b1000; c++) begin
            last_err = terr;
            step();
            if (valid == 4'b1000) busy++;
        end
        chk("to_busy_cycles", 32'(busy), 32'd4096);
        chk("to_err_before", 32'(last_err), 32'd0);
        chk("to_release_valid", 32'(valid), 32'd0);
        chk("to_err_set", 32'(terr), 32'd1);
        req = 4'b0001; step();
        step();
        chk("to_next_grant", 32'(valid), 32'h1);
        chk("to_next_addr", 32'(cmd_addr), 32'(exp_addr[0]));
        set_in(4'b0000, 1'b1, 1'b0, 1'b0); step();
        set_in(4'b0000, 1'b0, 1'b1, 1'b0); step();
        chk("to_next_release", 32'(valid), 32'd0);
        chk("to_err_sticky", 32'(terr), 32'd1);

        // Async reset during BUSY.
        done = 1'b0; step();
        fs = 1'b1; step();
        fs = 1'b0; step();
        chk("ar_bank_pre", 32'(wrbank), 32'd1);
        req = 4'b0100; step();
        chk("ar_grant2", 32'(valid), 32'h4);
        set_in(4'b0000, 1'b1, 1'b0, 1'b0); step();
        rdy = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(valid), 32'd0);
        chk("ar_cmd_en", 32'(cmd_en), 32'd0);
        chk("ar_bank", 32'(wrbank), 32'd0);
        chk("ar_terr", 32'(terr), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1001; step();
        chk("ar_ptr_zero_grant", 32'(valid), 32'h1);
        set_in(4'b0000, 1'b1, 1'b0, 1'b0); step();
        set_in(4'b1000, 1'b0, 1'b1, 1'b0); step();
        done = 1'b0; step();
        step();
        chk("ar_grant3", 32'(valid), 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr_slave_arbiter.md
Name: ddr_slave_arbiter

Overview:
- Shares the single DDR burst-command port between up to 4 slave interface blocks (camera write, SD/eth read, etc.) using round-robin arbitration.
- Receives each slave's req, 25-bit address and burst length.
- Grants one slave at a time via its arbitrate_valid line, issues the DDR command and holds the grant until the DDR controller reports burst completion.
- Also owns the frame-bank rotation (slave_wrbank / slave_wr_load) consumed by all slaves.

Parameters:
- SLAVE_NUM, 4, number of requesters (1..4); unused req bits are ignored.
- TIMEOUT, 16'd4096, max ddr_clk cycles in BUSY before a forced release.
- BANK_NUM, 2'd3, highest bank index; the bank counter wraps from this value to 0.

Ports:
- ddr_clk  in  1  DDR user clock; all logic is synchronous to it.
- sys_rstn  in  1  asynchronous active-low reset.
- slave_req  in  4  per-slave request; level, held by the slave until it sees its valid.
- slave_waddr_bus  in  100  slave i address in bits [25i+24:25i].
- slave_burst_bus  in  40  slave i burst length in bits [10i+9:10i].
- arbitrate_valid  out  4  one-hot grant, held for the whole transaction.
- ddr_cmd_en  out  1  command request to the DDR controller.
- ddr_cmd_addr  out  25  address of the granted slave, registered.
- ddr_cmd_bl  out  10  burst length of the granted slave, registered.
- ddr_cmd_ready  in  1  controller accepts the command when ddr_cmd_en && ddr_cmd_ready.
- ddr_burst_done  in  1  one-cycle pulse at the end of the data phase.
- frame_sync  in  1  one-cycle pulse (camera_vsync_neg) requesting a bank rotation.
- slave_wrbank  out  2  current write bank, broadcast to all slaves.
- slave_wr_load  out  1  one-cycle pulse when slave_wrbank has just changed.
- timeout_err  out  1  sticky flag; cleared only by reset.

Behaviour:
- Reset values: state=IDLE; all outputs 0; round-robin pointer=0; no bank rotation pending.

State machine: IDLE -> CMD -> BUSY -> RELEASE -> IDLE.
- IDLE:
  - If (slave_req & mask) != 0, select the first set bit at or above the pointer, wrapping (e.g. ptr=2, req=4'b0011 -> grant 0).
  - Register the grant index, ddr_cmd_addr and ddr_cmd_bl; go to CMD.
  - arbitrate_valid[g] and ddr_cmd_en rise on the same clock edge as the entry to CMD: 1 cycle latency from req sampled.
- CMD:
  - Hold ddr_cmd_en=1 with addr/bl stable until ddr_cmd_ready.
  - Handshake cycle -> BUSY; ddr_cmd_en drops on the next edge.
- BUSY:
  - arbitrate_valid[g] stays 1; a cycle counter runs.
  - ddr_burst_done -> RELEASE.
  - Counter reaching TIMEOUT-1 -> set timeout_err, go to RELEASE.
- RELEASE:
  - arbitrate_valid goes all-zero on entry; slaves use its falling edge to advance their address.
  - pointer <= (g+1) mod SLAVE_NUM; go to IDLE.
  - Minimum one idle cycle between two grants, so every valid falling edge is observable.
- ddr_burst_done outside BUSY is ignored; ddr_cmd_ready outside CMD is ignored.
- A slave dropping slave_req after its grant does not abort the transaction.

Bank rotation:
- frame_sync sets a pending flag.
- While state is IDLE and pending:
  - slave_wrbank <= (slave_wrbank==BANK_NUM) ? 0 : slave_wrbank+1.
  - slave_wr_load=1 for exactly that one cycle; pending cleared.
  - The arbiter grants nothing in that cycle.
- frame_sync during CMD/BUSY/RELEASE defers the rotation to the next IDLE cycle, so the bank never changes mid-burst.
- Multiple frame_sync pulses while pending collapse to one rotation.
- frame_sync coincident with a pending commit: the commit happens and pending remains set.

Reset mid-operation: asynchronous return to the reset state. Any outstanding DDR command is abandoned; the DDR controller is reset by the same sys_rstn.

Test Plan:
- Single requester: slave_req=4'b0010, addr1=25'h0040100, bl1=256; ready on 3rd CMD cycle, done 40 cycles later -> valid=4'b0010 from cycle 1 through BUSY; cmd_addr=25'h0040100, cmd_bl=256; valid low in RELEASE; pointer=2.
- Round-robin fairness: all 4 reqs held high continuously, ready/done immediate -> grant order 0,1,2,3,0, each separated by RELEASE+IDLE; no slave granted twice before the others.
- Backpressure: ddr_cmd_ready held low 100 cycles -> cmd_en, addr and bl stable for all 100 cycles; no BUSY entry; valid held.
- Bank deferral: frame_sync pulsed mid-BUSY with slave_wrbank=3 -> no change until the first IDLE cycle after RELEASE, then slave_wrbank=0 with a 1-cycle slave_wr_load; no grant in that cycle.
- Timeout: grant slave 3, never pulse ddr_burst_done -> RELEASE after TIMEOUT (4096) BUSY cycles; timeout_err=1 and stays 1; next request is served normally.
- Async reset asserted during BUSY -> arbitrate_valid, ddr_cmd_en, slave_wrbank, timeout_err all 0 immediately; after release, req=4'b1000 is granted with pointer starting at 0.
